// File: rtl/fetch_stage_pkg.sv
// Shared instruction-bus types and fetch defaults for the MIPS core.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus between the IF stage (master) and the memory side (slave).
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input iresp);
    modport slave  (input ireq, output iresp);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction fetches, buffers a word across
// stalls and writes the IF/ID register. Redirects honour one delay slot.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      ibus,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        pcD,
    output logic [31:0]        instrD,
    output logic               validD
);

    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        tgt_valid_q, tgt_valid_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pcD_q, pcD_d;
    logic [31:0] instrD_q, instrD_d;
    logic        validD_q, validD_d;

    logic        fetch_ok;
    logic        redir;
    logic        deliver;
    logic [31:0] npc;
    logic        unused_addr_ok;

    assign unused_addr_ok = ibus.iresp.addr_ok;

    always_comb begin
        fetch_ok = (state_q == FETCH) && ibus.iresp.data_ok;
        redir    = redirect_valid && !stall;
        deliver  = !stall && (fetch_ok || (state_q == HOLD));

        if (redir)            npc = redirect_pc;
        else if (tgt_valid_q) npc = tgt_q;
        else                  npc = seq_pc(pc_q);

        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        tgt_valid_d = tgt_valid_q;
        buf_d       = buf_q;
        pcD_d       = pcD_q;
        instrD_d    = instrD_q;
        validD_d    = validD_q;

        // Delivery passes back through INIT so every launch is registered,
        // giving one fetch per two cycles even on a zero-latency bus.
        case (state_q)
            INIT:    state_d = FETCH;
            FETCH:   if (fetch_ok) state_d = stall ? HOLD : INIT;
            HOLD:    if (!stall) state_d = INIT;
            default: state_d = INIT;
        endcase

        if (fetch_ok && stall) buf_d = ibus.iresp.data;

        if (deliver) begin
            pc_d        = npc;
            tgt_valid_d = 1'b0;
            pcD_d       = pc_q;
            instrD_d    = (state_q == HOLD) ? buf_q : ibus.iresp.data;
            validD_d    = 1'b1;
        end else begin
            if (redir) begin
                tgt_d       = redirect_pc;
                tgt_valid_d = 1'b1;
            end
            if (!stall) begin
                validD_d = 1'b0;
                instrD_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            tgt_valid_q <= 1'b0;
            buf_q       <= '0;
            pcD_q       <= '0;
            instrD_q    <= '0;
            validD_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            tgt_valid_q <= tgt_valid_d;
            buf_q       <= buf_d;
            pcD_q       <= pcD_d;
            instrD_q    <= instrD_d;
            validD_q    <= validD_d;
        end
    end

    assign ibus.ireq.valid = (state_q == FETCH);
    assign ibus.ireq.addr  = pc_q;
    assign pcD             = pcD_q;
    assign instrD          = instrD_q;
    assign validD          = validD_q;

endmodule
